bram_fifo_ctrl: RTL and testbench
=================================

BRAM_FIFO_CTRL -- requirements
Module: bram_fifo_ctrl

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 11, RAM address width; storage depth is 2^ADDR_BITS entries (2048).
REQ-002 SHALL have parameter DATA_BITS, default 8, RAM data width.
REQ-003 SHALL have parameter ALMOST_FULL, default 2040, level at or above which ALMOST_FULL_O is high.
REQ-004 CLK  input  1  single clock for all logic and both RAM ports.
REQ-005 RESET_N  input  1  asynchronous, active-low reset.
REQ-006 FLUSH  input  1  synchronous clear of all contents.
REQ-007 IN_VALID  input  1  upstream data valid.
REQ-008 IN_READY  output  1  block can accept a word this cycle.
REQ-009 IN_DATA  input  DATA_BITS  upstream word.
REQ-010 OUT_VALID  output  1  OUT_DATA holds a valid word.
REQ-011 OUT_READY  input  1  downstream accepts the word.
REQ-012 OUT_DATA  output  DATA_BITS  head word, wired directly from RAM_DOB.
REQ-013 RAM_ENA, RAM_WEA  output  1 each  port-A enable/write enable (port A is write-only).
REQ-014 RAM_ADDRA  output  ADDR_BITS  write address; RAM_DIA  output  DATA_BITS  write data.
REQ-015 RAM_ENB  output  1  port-B read enable (port B is read-only; WEB tied low externally).
REQ-016 RAM_ADDRB  output  ADDR_BITS  read address; RAM_DOB  input  DATA_BITS  registered read data, 1-cycle latency, held while RAM_ENB low.
REQ-017 LEVEL  output  ADDR_BITS+2  words held (RAM storage count + OUT_VALID), 0..2^ADDR_BITS+1.
REQ-018 ALMOST_FULL_O  output  1  LEVEL >= ALMOST_FULL, registered.

Function
REQ-019 SHALL keep wr_ptr, rd_ptr (ADDR_BITS, wrap 2^ADDR_BITS-1 -> 0 naturally) and stor_cnt (ADDR_BITS+1, 0..2^ADDR_BITS) counting words written to the RAM but not yet read out of it.
REQ-020 IN_READY SHALL be combinational: stor_cnt < 2^ADDR_BITS and FLUSH low and RESET_N high.
REQ-021 Write fire (IN_VALID && IN_READY) SHALL drive RAM_ENA=RAM_WEA=1, RAM_ADDRA=wr_ptr, RAM_DIA=IN_DATA, and increment wr_ptr at the edge; otherwise RAM_ENA=RAM_WEA=0.
REQ-022 Read issue SHALL be combinational: stor_cnt > 0 and (OUT_VALID==0 or OUT_READY==1) and FLUSH low; drives RAM_ENB=1, RAM_ADDRB=rd_ptr, increments rd_ptr at the edge.
REQ-023 OUT_VALID next = 1 on read issue; else 0 if OUT_READY; else hold. With RAM_ENB low the RAM holds RAM_DOB, so OUT_DATA is stable while OUT_VALID && !OUT_READY.
REQ-024 stor_cnt SHALL be +1 on write fire only, -1 on read issue only, unchanged when both or neither occur in the same cycle.
REQ-025 Read issue SHALL never target an address written in the same cycle (stor_cnt>0 guarantees rd_ptr != wr_ptr unless full, when writes are blocked).
REQ-026 Latency: word accepted at edge t is read at edge t+1 when the output is free; OUT_VALID high after edge t+1 (2 cycles in->out).
REQ-027 Throughput SHALL be 1 word/cycle in and out simultaneously when neither side stalls.
REQ-028 Full: stor_cnt==2^ADDR_BITS -> IN_READY=0; a simultaneous read issue re-opens IN_READY the next cycle, not the same cycle.
REQ-029 Empty: stor_cnt==0 -> no read issue; OUT_VALID may still be 1 holding the last word.
REQ-030 FLUSH high at an edge SHALL set wr_ptr, rd_ptr, stor_cnt, OUT_VALID to 0, suppress write fire and read issue that cycle, and win over all other events.
REQ-031 LEVEL and ALMOST_FULL_O SHALL be registered from the next-state values (valid the cycle after the change).

Reset
REQ-032 RESET_N low SHALL asynchronously clear wr_ptr, rd_ptr, stor_cnt, OUT_VALID, LEVEL, ALMOST_FULL_O to 0; IN_READY, RAM_ENA, RAM_WEA, RAM_ENB SHALL be 0 while RESET_N is low.
REQ-033 Reset asserted mid-transfer SHALL discard all contents; the first word after release SHALL be read from address 0.
REQ-034 RAM contents SHALL not be cleared; the block SHALL never present unwritten RAM data with OUT_VALID high.

Verification
REQ-035 Reset release, push 0x11,0x22,0x33 on consecutive cycles, OUT_READY=1 -> OUT_DATA 0x11,0x22,0x33 on 3 consecutive cycles, first 2 cycles after first accept; LEVEL returns to 0.
REQ-036 OUT_READY=0, push 2049 words -> IN_READY drops after 2049 accepts (2048 stored + 1 in output), LEVEL=2049, ALMOST_FULL_O=1; OUT_DATA stays word 0.
REQ-037 From full, hold IN_VALID=1 and pulse OUT_READY for 1 cycle -> exactly one more word accepted the following cycle; order preserved.
REQ-038 Stream 5000 words with random IN_VALID/OUT_READY -> output sequence equals input sequence across pointer wrap at 2047->0; no RAM_ENB at RAM_ADDRB==RAM_ADDRA while RAM_WEA high.
REQ-039 FLUSH with LEVEL=10 and simultaneous IN_VALID=1 -> LEVEL=0, OUT_VALID=0 next cycle, no write fire that cycle; next push 0xA5 appears at OUT_DATA 2 cycles later.
REQ-040 Assert RESET_N low mid-stream asynchronously -> OUT_VALID, IN_READY, RAM enables go low immediately; after release, the first word pushed is written to and read from address 0.

Source files
------------

// File: rtl/bram_fifo_ctrl.sv
// bram_fifo_ctrl: FIFO control for an external simple dual-port BRAM with 1-cycle registered read.
// The RAM output register doubles as the FIFO output stage, so LEVEL = stored words + OUT_VALID.
module bram_fifo_ctrl #(
  parameter int ADDR_BITS   = 11,
  parameter int DATA_BITS   = 8,
  parameter int ALMOST_FULL = 2040
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic                   FLUSH,
  input  logic                   IN_VALID,
  output logic                   IN_READY,
  input  logic [DATA_BITS-1:0]   IN_DATA,
  output logic                   OUT_VALID,
  input  logic                   OUT_READY,
  output logic [DATA_BITS-1:0]   OUT_DATA,
  output logic                   RAM_ENA,
  output logic                   RAM_WEA,
  output logic [ADDR_BITS-1:0]   RAM_ADDRA,
  output logic [DATA_BITS-1:0]   RAM_DIA,
  output logic                   RAM_ENB,
  output logic [ADDR_BITS-1:0]   RAM_ADDRB,
  input  logic [DATA_BITS-1:0]   RAM_DOB,
  output logic [ADDR_BITS+1:0]   LEVEL,
  output logic                   ALMOST_FULL_O
);
  localparam logic [ADDR_BITS+1:0] AF_LVL = (ADDR_BITS+2)'(ALMOST_FULL);
  logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_BITS:0]   stor_cnt_q, stor_cnt_d;
  logic [ADDR_BITS+1:0] level_q, level_d;
  logic                 out_valid_q, out_valid_d, af_q, wr_fire, rd_issue;
  // stor_cnt can only reach 2^ADDR_BITS, so its top bit alone flags full
  assign IN_READY  = RESET_N && !FLUSH && !stor_cnt_q[ADDR_BITS];
  assign wr_fire   = IN_VALID && IN_READY;
  assign rd_issue  = RESET_N && !FLUSH && (stor_cnt_q != '0) && (!out_valid_q || OUT_READY);
  assign RAM_ENA   = wr_fire;
  assign RAM_WEA   = wr_fire;
  assign RAM_ADDRA = wr_ptr_q;
  assign RAM_DIA   = IN_DATA;
  assign RAM_ENB   = rd_issue;
  assign RAM_ADDRB = rd_ptr_q;
  assign OUT_DATA  = RAM_DOB;
  assign OUT_VALID = out_valid_q;
  assign LEVEL     = level_q;
  assign ALMOST_FULL_O = af_q;
  always_comb begin
    wr_ptr_d    = FLUSH ? '0 : wr_ptr_q + ADDR_BITS'(wr_fire);
    rd_ptr_d    = FLUSH ? '0 : rd_ptr_q + ADDR_BITS'(rd_issue);
    stor_cnt_d  = FLUSH ? '0 : stor_cnt_q + (ADDR_BITS+1)'(wr_fire) - (ADDR_BITS+1)'(rd_issue);
    out_valid_d = FLUSH ? 1'b0 : rd_issue ? 1'b1 : OUT_READY ? 1'b0 : out_valid_q;
    level_d     = (ADDR_BITS+2)'(stor_cnt_d) + (ADDR_BITS+2)'(out_valid_d);
  end
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      stor_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      level_q     <= '0;
      af_q        <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      stor_cnt_q  <= stor_cnt_d;
      out_valid_q <= out_valid_d;
      level_q     <= level_d;
      af_q        <= level_d >= AF_LVL;
    end
  end
endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// tb_bram_fifo_ctrl: directed vector table plus corner-case sequences against a behavioural BRAM.
module tb_bram_fifo_ctrl;
  logic        CLK = 1'b0, RESET_N, FLUSH, IN_VALID, IN_READY, OUT_VALID, OUT_READY;
  logic [7:0]  IN_DATA, OUT_DATA, RAM_DIA, RAM_DOB;
  logic        RAM_ENA, RAM_WEA, RAM_ENB, ALMOST_FULL_O;
  logic [10:0] RAM_ADDRA, RAM_ADDRB;
  logic [12:0] LEVEL;
  logic [7:0]  mem [0:2047];
  int          total = 0, passed = 0;

  bram_fifo_ctrl dut (
    .CLK(CLK), .RESET_N(RESET_N), .FLUSH(FLUSH), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_DATA(IN_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
    .RAM_ENA(RAM_ENA), .RAM_WEA(RAM_WEA), .RAM_ADDRA(RAM_ADDRA), .RAM_DIA(RAM_DIA),
    .RAM_ENB(RAM_ENB), .RAM_ADDRB(RAM_ADDRB), .RAM_DOB(RAM_DOB), .LEVEL(LEVEL),
    .ALMOST_FULL_O(ALMOST_FULL_O)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (RAM_ENA && RAM_WEA) mem[RAM_ADDRA] <= RAM_DIA;
    if (RAM_ENB) RAM_DOB <= mem[RAM_ADDRB];
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", n, act, exp);
  endtask

  always @(negedge CLK)
    if (RESET_N && RAM_ENB && RAM_ENA && RAM_WEA)
      chk("rw_collision", 32'(RAM_ADDRB == RAM_ADDRA), 32'(0));

  function automatic logic [7:0] wd(input int i);
    return 8'(i * 7 + 3);
  endfunction

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  typedef struct {
    logic        iv;
    logic [7:0]  id;
    logic        ordy;
    logic        e_ov;
    logic [7:0]  e_od;
    logic [12:0] e_lvl;
  } vec_t;
  vec_t vt[10];

  logic [7:0] q[$];
  int acc, idx, sent, got;

  initial begin
    vt[0] = '{1'b1, 8'h11, 1'b1, 1'b0, 8'h00, 13'd0};
    vt[1] = '{1'b1, 8'h22, 1'b1, 1'b0, 8'h00, 13'd1};
    vt[2] = '{1'b1, 8'h33, 1'b1, 1'b1, 8'h11, 13'd2};
    vt[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h22, 13'd2};
    vt[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h33, 13'd1};
    vt[5] = '{1'b1, 8'h44, 1'b0, 1'b0, 8'h00, 13'd0};
    vt[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 13'd1};
    vt[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h44, 13'd1};
    vt[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h44, 13'd1};
    vt[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 13'd0};
    RESET_N = 1'b0; FLUSH = 1'b0; IN_VALID = 1'b1; OUT_READY = 1'b0; IN_DATA = 8'h00;
    repeat (2) tick;
    chk("rst_in_ready", 32'(IN_READY), 32'(0));
    chk("rst_ena", 32'(RAM_ENA), 32'(0));
    IN_VALID = 1'b0;
    RESET_N = 1'b1;
    #1;
    chk("rst_out_valid", 32'(OUT_VALID), 32'(0));
    chk("rst_level", 32'(LEVEL), 32'(0));
    chk("rst_af", 32'(ALMOST_FULL_O), 32'(0));
    chk("rst_in_ready_rel", 32'(IN_READY), 32'(1));
    foreach (vt[i]) begin
      IN_VALID = vt[i].iv; IN_DATA = vt[i].id; OUT_READY = vt[i].ordy;
      #1;
      chk($sformatf("vec%0d_in_ready", i), 32'(IN_READY), 32'(1));
      chk($sformatf("vec%0d_out_valid", i), 32'(OUT_VALID), 32'(vt[i].e_ov));
      if (vt[i].e_ov) chk($sformatf("vec%0d_out_data", i), 32'(OUT_DATA), 32'(vt[i].e_od));
      chk($sformatf("vec%0d_level", i), 32'(LEVEL), 32'(vt[i].e_lvl));
      tick;
    end
    // fill to full with the output stalled
    acc = 0;
    OUT_READY = 1'b0;
    for (int c = 0; c < 3000 && acc < 2100; c++) begin
      IN_VALID = 1'b1; IN_DATA = wd(acc);
      #1;
      if (!IN_READY) break;
      tick;
      acc++;
      if (acc == 2039) chk("af_below", 32'(ALMOST_FULL_O), 32'(0));
      if (acc == 2040) chk("af_at", 32'(ALMOST_FULL_O), 32'(1));
    end
    chk("full_accepts", 32'(acc), 32'(2049));
    chk("full_in_ready", 32'(IN_READY), 32'(0));
    chk("full_level", 32'(LEVEL), 32'(2049));
    chk("full_af", 32'(ALMOST_FULL_O), 32'(1));
    chk("full_out_valid", 32'(OUT_VALID), 32'(1));
    chk("full_head", 32'(OUT_DATA), 32'(wd(0)));
    // single OUT_READY pulse from full
    OUT_READY = 1'b1;
    #1;
    chk("pulse_in_ready_same", 32'(IN_READY), 32'(0));
    tick;
    OUT_READY = 1'b0; IN_DATA = wd(2049);
    #1;
    chk("pulse_in_ready_next", 32'(IN_READY), 32'(1));
    chk("pulse_head", 32'(OUT_DATA), 32'(wd(1)));
    tick;
    IN_DATA = wd(2050);
    #1;
    chk("pulse_refull", 32'(IN_READY), 32'(0));
    chk("pulse_level", 32'(LEVEL), 32'(2049));
    IN_VALID = 1'b0; OUT_READY = 1'b1; idx = 1;
    for (int c = 0; c < 2200; c++) begin
      if (!OUT_VALID) break;
      chk("drain_data", 32'(OUT_DATA), 32'(wd(idx)));
      idx++;
      tick;
    end
    chk("drain_count", 32'(idx), 32'(2050));
    chk("drain_level", 32'(LEVEL), 32'(0));
    // random stream across pointer wrap
    sent = 0; got = 0;
    for (int c = 0; c < 40000 && got < 5000; c++) begin
      IN_VALID = (sent < 5000) && ($urandom_range(0, 3) != 0);
      IN_DATA = 8'($urandom);
      OUT_READY = $urandom_range(0, 3) != 0;
      #1;
      if (OUT_VALID && OUT_READY) begin
        if (q.size() == 0) chk("stream_spurious", 32'(1), 32'(0));
        else begin
          chk("stream_data", 32'(OUT_DATA), 32'(q.pop_front()));
          got++;
        end
      end
      if (IN_VALID && IN_READY) begin
        q.push_back(IN_DATA);
        sent++;
      end
      tick;
    end
    chk("stream_count", 32'(got), 32'(5000));
    IN_VALID = 1'b0; OUT_READY = 1'b1;
    repeat (3) tick;
    // flush with LEVEL=10 and a concurrent push
    OUT_READY = 1'b0; IN_VALID = 1'b1;
    for (int j = 0; j < 10; j++) begin
      IN_DATA = 8'(8'h40 + j);
      tick;
    end
    chk("flush_pre_level", 32'(LEVEL), 32'(10));
    FLUSH = 1'b1; IN_DATA = 8'hEE;
    #1;
    chk("flush_in_ready", 32'(IN_READY), 32'(0));
    chk("flush_ena", 32'(RAM_ENA), 32'(0));
    chk("flush_enb", 32'(RAM_ENB), 32'(0));
    tick;
    FLUSH = 1'b0; IN_DATA = 8'hA5; OUT_READY = 1'b1;
    #1;
    chk("flush_level", 32'(LEVEL), 32'(0));
    chk("flush_out_valid", 32'(OUT_VALID), 32'(0));
    chk("flush_addra", 32'(RAM_ADDRA), 32'(0));
    tick;
    IN_VALID = 1'b0;
    #1;
    chk("flush_ov_t1", 32'(OUT_VALID), 32'(0));
    chk("flush_addrb", 32'(RAM_ADDRB), 32'(0));
    tick;
    chk("flush_ov_t2", 32'(OUT_VALID), 32'(1));
    chk("flush_a5", 32'(OUT_DATA), 32'(8'hA5));
    chk("flush_level1", 32'(LEVEL), 32'(1));
    // asynchronous reset mid-stream
    IN_VALID = 1'b1;
    for (int j = 0; j < 5; j++) begin
      IN_DATA = 8'(8'h60 + j);
      tick;
    end
    #2;
    RESET_N = 1'b0;
    #1;
    chk("arst_out_valid", 32'(OUT_VALID), 32'(0));
    chk("arst_in_ready", 32'(IN_READY), 32'(0));
    chk("arst_ena", 32'(RAM_ENA), 32'(0));
    chk("arst_enb", 32'(RAM_ENB), 32'(0));
    chk("arst_level", 32'(LEVEL), 32'(0));
    tick;
    RESET_N = 1'b1; IN_DATA = 8'hB7;
    #1;
    chk("arst_wr_en", 32'(RAM_ENA), 32'(1));
    chk("arst_wr_addr", 32'(RAM_ADDRA), 32'(0));
    tick;
    IN_VALID = 1'b0;
    #1;
    chk("arst_rd_en", 32'(RAM_ENB), 32'(1));
    chk("arst_rd_addr", 32'(RAM_ADDRB), 32'(0));
    tick;
    chk("arst_out_valid2", 32'(OUT_VALID), 32'(1));
    chk("arst_data", 32'(OUT_DATA), 32'(8'hB7));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
